tri_raster_scan: RTL and testbench

Bounding-box raster scanner that drives the point-in-triangle test stage. Accepts one triangle (three 11-bit vertices) over a valid/ready handshake, computes its screen-clamped bounding box, steps a test point (Px, Py) through every pixel of the box in row-major order, waits a fixed latency for the downstream inside/outside test, and emits one (x, y, inside) record per pixel to the frame-buffer writer.

---
 rtl/tri_pkg.sv | 32 +++
 rtl/tri_raster_scan_if.sv | 29 ++
 rtl/tri_bbox.sv | 24 ++
 rtl/tri_raster_scan.sv | 123 ++++++++++++
 tb/tb_tri_raster_scan.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tri_pkg.sv
// Shared types and screen limits for the raster scanner and the inside-test stage.
package tri_pkg;
  localparam int COORD_W = 11;
  localparam int H_MAX   = 639;
  localparam int V_MAX   = 479;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_BBOX = 3'd1;
  localparam state_t S_WAIT = 3'd2;
  localparam state_t S_OUT  = 3'd3;
  localparam state_t S_DONE = 3'd4;

  function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/tri_raster_scan_if.sv
// Triangle-in / pixel-out bus between the scanner and its neighbours.
interface tri_raster_scan_if;
  import tri_pkg::*;

  logic   tri_valid;
  logic   tri_ready;
  coord_t ax, ay, bx, by, cx, cy;
  coord_t t_ax, t_ay, t_bx, t_by, t_cx, t_cy;
  coord_t Px, Py;
  logic   inside_flag;
  logic   pix_valid;
  logic   pix_ready;
  coord_t pix_x, pix_y;
  logic   pix_inside;
  logic   busy;
  logic   done;

  modport slave (
    input  tri_valid, ax, ay, bx, by, cx, cy, inside_flag, pix_ready,
    output tri_ready, t_ax, t_ay, t_bx, t_by, t_cx, t_cy, Px, Py,
           pix_valid, pix_x, pix_y, pix_inside, busy, done
  );

  modport master (
    output tri_valid, ax, ay, bx, by, cx, cy, inside_flag, pix_ready,
    input  tri_ready, t_ax, t_ay, t_bx, t_by, t_cx, t_cy, Px, Py,
           pix_valid, pix_x, pix_y, pix_inside, busy, done
  );
endinterface

// File: rtl/tri_bbox.sv
// Bounding box of three points, max edges clamped to the visible screen.
module tri_bbox import tri_pkg::*; (
  input  point_t i_p0,
  input  point_t i_p1,
  input  point_t i_p2,
  output coord_t o_xmin,
  output coord_t o_xmax,
  output coord_t o_ymin,
  output coord_t o_ymax,
  output logic   o_off
);
  coord_t w_xmax_raw, w_ymax_raw;

  assign o_xmin     = min3(i_p0.x, i_p1.x, i_p2.x);
  assign o_ymin     = min3(i_p0.y, i_p1.y, i_p2.y);
  assign w_xmax_raw = max3(i_p0.x, i_p1.x, i_p2.x);
  assign w_ymax_raw = max3(i_p0.y, i_p1.y, i_p2.y);

  assign o_xmax = (w_xmax_raw > coord_t'(H_MAX)) ? coord_t'(H_MAX) : w_xmax_raw;
  assign o_ymax = (w_ymax_raw > coord_t'(V_MAX)) ? coord_t'(V_MAX) : w_ymax_raw;

  // A box starting past the screen edge has no visible pixel at all.
  assign o_off = (o_xmin > coord_t'(H_MAX)) || (o_ymin > coord_t'(V_MAX));
endmodule

// File: rtl/tri_raster_scan.sv
// Walks every pixel of a triangle's clamped bounding box, waits TEST_LAT for
// the inside test, and emits one (x, y, inside) record per pixel.
module tri_raster_scan import tri_pkg::*; #(
  parameter int TEST_LAT = 3
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  tri_raster_scan_if.slave bus
);
  localparam int CNT_W = $clog2(TEST_LAT + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LOAD = cnt_t'(TEST_LAT);

  state_t r_state;
  cnt_t   r_cnt;
  coord_t r_t_ax, r_t_ay, r_t_bx, r_t_by, r_t_cx, r_t_cy;
  coord_t r_px, r_py;
  coord_t r_xmin, r_xmax, r_ymax;
  coord_t r_pix_x, r_pix_y;
  logic   r_pix_inside;

  coord_t w_xmin, w_xmax, w_ymin, w_ymax;
  logic   w_off;

  tri_bbox u_bbox (
    .i_p0   ('{x: r_t_ax, y: r_t_ay}),
    .i_p1   ('{x: r_t_bx, y: r_t_by}),
    .i_p2   ('{x: r_t_cx, y: r_t_cy}),
    .o_xmin (w_xmin),
    .o_xmax (w_xmax),
    .o_ymin (w_ymin),
    .o_ymax (w_ymax),
    .o_off  (w_off)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_t_ax       <= '0;
      r_t_ay       <= '0;
      r_t_bx       <= '0;
      r_t_by       <= '0;
      r_t_cx       <= '0;
      r_t_cy       <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_xmin       <= '0;
      r_xmax       <= '0;
      r_ymax       <= '0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_inside <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.tri_valid) begin
          r_t_ax  <= bus.ax;
          r_t_ay  <= bus.ay;
          r_t_bx  <= bus.bx;
          r_t_by  <= bus.by;
          r_t_cx  <= bus.cx;
          r_t_cy  <= bus.cy;
          r_state <= S_BBOX;
        end
        S_BBOX: begin
          r_xmin <= w_xmin;
          r_xmax <= w_xmax;
          r_ymax <= w_ymax;
          if (w_off) begin
            r_state <= S_DONE;
          end else begin
            r_px    <= w_xmin;
            r_py    <= w_ymin;
            r_cnt   <= CNT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The test stage result is valid on the last count of the latency window.
          if (r_cnt == cnt_t'(1)) begin
            r_pix_inside <= bus.inside_flag;
            r_pix_x      <= r_px;
            r_pix_y      <= r_py;
            r_state      <= S_OUT;
          end
          r_cnt <= r_cnt - cnt_t'(1);
        end
        S_OUT: if (bus.pix_ready) begin
          if (r_px == r_xmax && r_py == r_ymax) begin
            r_state <= S_DONE;
          end else begin
            if (r_px == r_xmax) begin
              r_px <= r_xmin;
              r_py <= r_py + coord_t'(1);
            end else begin
              r_px <= r_px + coord_t'(1);
            end
            r_cnt   <= CNT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tri_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.pix_valid  = (r_state == S_OUT);
  assign bus.done       = (r_state == S_DONE);
  assign bus.t_ax       = r_t_ax;
  assign bus.t_ay       = r_t_ay;
  assign bus.t_bx       = r_t_bx;
  assign bus.t_by       = r_t_by;
  assign bus.t_cx       = r_t_cx;
  assign bus.t_cy       = r_t_cy;
  assign bus.Px         = r_px;
  assign bus.Py         = r_py;
  assign bus.pix_x      = r_pix_x;
  assign bus.pix_y      = r_pix_y;
  assign bus.pix_inside = r_pix_inside;
endmodule

// File: tb/tb_tri_raster_scan.sv
// Directed bench for tri_raster_scan; inside test modelled as Px+Py <= 22.
module tb_tri_raster_scan;
  import tri_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  int   rec_x [256];
  int   rec_y [256];
  logic rec_in[256];
  coord_t cur[6];

  tri_raster_scan_if bus();

  tri_raster_scan #(.TEST_LAT(3)) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  assign bus.inside_flag = (int'(bus.Px) + int'(bus.Py)) <= 22;

  task automatic send_tri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy);
    bus.ax = coord_t'(ax); bus.ay = coord_t'(ay);
    bus.bx = coord_t'(bx); bus.by = coord_t'(by);
    bus.cx = coord_t'(cx); bus.cy = coord_t'(cy);
    bus.tri_valid = 1'b1;
    for (int i = 0; i < 500 && !bus.tri_ready; i++) @(negedge clk);
    if (!bus.tri_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout tri_ready=%b required 1", bus.tri_ready);
    end
    cur[0] = coord_t'(ax); cur[1] = coord_t'(ay); cur[2] = coord_t'(bx);
    cur[3] = coord_t'(by); cur[4] = coord_t'(cx); cur[5] = coord_t'(cy);
    @(negedge clk);
    bus.tri_valid = 1'b0;
  endtask

  // Starts at the first negedge after acceptance (cycle 0); returns on the done cycle.
  task automatic collect(input int max_cyc, input bit rnd, output int n,
                         output int done_cyc, output int bad);
    logic held;
    int   hx, hy;
    logic hin;
    n = 0; done_cyc = -1; bad = 0; held = 1'b0; hx = 0; hy = 0; hin = 1'b0;
    for (int i = 0; i < 256; i++) begin rec_x[i] = -1; rec_y[i] = -1; rec_in[i] = 1'bx; end
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (bus.done) begin done_cyc = cyc; break; end
      if (!bus.busy || bus.tri_ready) bad++;
      if ({bus.t_ax, bus.t_ay, bus.t_bx, bus.t_by, bus.t_cx, bus.t_cy} !==
          {cur[0], cur[1], cur[2], cur[3], cur[4], cur[5]}) bad++;
      if (bus.pix_valid) begin
        if (!held) begin
          if (n < 256) begin
            rec_x[n] = int'(bus.pix_x); rec_y[n] = int'(bus.pix_y); rec_in[n] = bus.pix_inside;
          end
          n++;
          held = 1'b1; hx = int'(bus.pix_x); hy = int'(bus.pix_y); hin = bus.pix_inside;
        end else if (int'(bus.pix_x) != hx || int'(bus.pix_y) != hy || bus.pix_inside !== hin) begin
          bad++;
        end
      end else if (held) begin
        bad++;
      end
      bus.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.pix_valid && bus.pix_ready) held = 1'b0;
      @(negedge clk);
    end
    bus.pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    bus.tri_valid = 1'b0; bus.pix_ready = 1'b1;
    bus.ax = '0; bus.ay = '0; bus.bx = '0; bus.by = '0; bus.cx = '0; bus.cy = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.tri_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_tri_ready got %b want 1", bus.tri_ready);
    end
    n_tests++;
    if ({bus.pix_valid, bus.busy, bus.done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {bus.pix_valid, bus.busy, bus.done});
    end
    n_tests++;
    if ({bus.Px, bus.Py, bus.pix_x, bus.pix_y, bus.pix_inside} !== '0) begin
      n_fail++; $display("FAIL reset_coords Px=%0d Py=%0d x=%0d y=%0d in=%b want all 0",
                         bus.Px, bus.Py, bus.pix_x, bus.pix_y, bus.pix_inside);
    end
    n_tests++;
    if ({bus.t_ax, bus.t_ay, bus.t_bx, bus.t_by, bus.t_cx, bus.t_cy} !== '0) begin
      n_fail++; $display("FAIL reset_tverts got nonzero want 0");
    end
  endtask

  task automatic check_box(input string name, input int x0, input int y0, input int w,
                           input int cnt);
    int ex, ey;
    logic ein;
    for (int i = 0; i < cnt; i++) begin
      ex = x0 + i % w; ey = y0 + i / w; ein = (ex + ey) <= 22;
      n_tests++;
      if (rec_x[i] != ex || rec_y[i] != ey || rec_in[i] !== ein) begin
        n_fail++;
        $display("FAIL %s_rec%0d got (%0d,%0d,%b) want (%0d,%0d,%b)", name, i,
                 rec_x[i], rec_y[i], rec_in[i], ex, ey, ein);
      end
    end
  endtask

  task automatic test_basic();
    int n, dc, bad;
    send_tri(10, 10, 12, 10, 10, 12);
    collect(200, 1'b0, n, dc, bad);
    n_tests++;
    if (n != 9) begin n_fail++; $display("FAIL basic_count got %0d want 9", n); end
    n_tests++;
    // BBOX + 9 pixels x 4 cycles, done visible 37 edges after the accept edge
    if (dc != 37) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 37", dc); end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL basic_protocol got %0d errors want 0", bad); end
    check_box("basic", 10, 10, 3, 9);
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0 || bus.tri_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_done_pulse done=%b ready=%b want 0/1", bus.done, bus.tri_ready);
    end
  endtask

  task automatic test_backpressure();
    int n, dc, bad;
    send_tri(10, 10, 12, 10, 10, 12);
    collect(2000, 1'b1, n, dc, bad);
    n_tests++;
    if (n != 9 || dc < 37) begin
      n_fail++; $display("FAIL bp_count got n=%0d done=%0d want 9 and >=37", n, dc);
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL bp_stability got %0d errors want 0", bad); end
    check_box("bp", 10, 10, 3, 9);
    @(negedge clk);
  endtask

  task automatic test_clamp();
    int n, dc, bad;
    send_tri(630, 470, 700, 470, 630, 500);
    collect(2000, 1'b0, n, dc, bad);
    n_tests++;
    if (n != 100) begin n_fail++; $display("FAIL clamp_count got %0d want 100", n); end
    n_tests++;
    if (dc != 401) begin n_fail++; $display("FAIL clamp_done_cycle got %0d want 401", dc); end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL clamp_protocol got %0d errors want 0", bad); end
    check_box("clamp", 630, 470, 10, 100);
    @(negedge clk);
  endtask

  task automatic test_offscreen();
    int n, dc, bad;
    send_tri(640, 5, 700, 5, 650, 20);
    collect(50, 1'b0, n, dc, bad);
    n_tests++;
    if (n != 0 || dc != 1) begin
      n_fail++; $display("FAIL offx got n=%0d done=%0d want 0/1", n, dc);
    end
    @(negedge clk);
    send_tri(5, 480, 6, 490, 7, 500);
    collect(50, 1'b0, n, dc, bad);
    n_tests++;
    if (n != 0 || dc != 1) begin
      n_fail++; $display("FAIL offy got n=%0d done=%0d want 0/1", n, dc);
    end
    @(negedge clk);
    send_tri(639, 479, 639, 479, 639, 479);
    collect(50, 1'b0, n, dc, bad);
    n_tests++;
    if (n != 1 || dc != 5 || bad != 0) begin
      n_fail++; $display("FAIL corner got n=%0d done=%0d bad=%0d want 1/5/0", n, dc, bad);
    end
    check_box("corner", 639, 479, 1, 1);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, dc, bad;
    send_tri(10, 10, 12, 10, 10, 12);
    bus.ax = 11'd20; bus.ay = 11'd30; bus.bx = 11'd21;
    bus.by = 11'd30; bus.cx = 11'd20; bus.cy = 11'd31;
    bus.tri_valid = 1'b1;
    collect(200, 1'b0, n, dc, bad);
    n_tests++;
    if (n != 9 || dc != 37 || bad != 0) begin
      n_fail++; $display("FAIL b2b_first got n=%0d done=%0d bad=%0d want 9/37/0", n, dc, bad);
    end
    send_tri(20, 30, 21, 30, 20, 31);
    n_tests++;
    if (int'(bus.t_ax) != 20 || int'(bus.t_cy) != 31) begin
      n_fail++; $display("FAIL b2b_latch got t_ax=%0d t_cy=%0d want 20/31", bus.t_ax, bus.t_cy);
    end
    collect(200, 1'b0, n, dc, bad);
    n_tests++;
    if (n != 4 || dc != 17 || bad != 0) begin
      n_fail++; $display("FAIL b2b_second got n=%0d done=%0d bad=%0d want 4/17/0", n, dc, bad);
    end
    check_box("b2b", 20, 30, 2, 4);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen_done;
    bus.pix_ready = 1'b0;
    send_tri(10, 10, 12, 10, 10, 12);
    for (int i = 0; i < 50 && !bus.pix_valid; i++) @(negedge clk);
    n_tests++;
    if (bus.pix_valid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_reach_out pix_valid=%b want 1", bus.pix_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.pix_valid, bus.busy, bus.tri_ready, bus.done} !== 4'b0010) begin
      n_fail++; $display("FAIL rmid_state got v/b/r/d=%b want 0010",
                         {bus.pix_valid, bus.busy, bus.tri_ready, bus.done});
    end
    n_tests++;
    if ({bus.Px, bus.Py, bus.t_ax} !== '0) begin
      n_fail++; $display("FAIL rmid_regs Px=%0d Py=%0d t_ax=%0d want 0", bus.Px, bus.Py, bus.t_ax);
    end
    rst_n = 1'b1;
    bus.pix_ready = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done++;
    end
    n_tests++;
    if (seen_done != 0) begin
      n_fail++; $display("FAIL rmid_no_done got %0d done/busy cycles want 0", seen_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clamp();
    test_offscreen();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
